// File: rtl/quadra_sched_if.sv
// Requester, result and quadra-side signal bundle for quadra_sched.
// slave is the scheduler side, master the environment side.
interface quadra_sched_if #(
   parameter int X_W = 8,
   parameter int Y_W = 16
);
   logic           s0_valid;
   logic           s0_ready;
   logic [X_W-1:0] s0_x;
   logic           s1_valid;
   logic           s1_ready;
   logic [X_W-1:0] s1_x;
   logic           m0_valid;
   logic           m0_ready;
   logic [Y_W-1:0] m0_y;
   logic           m1_valid;
   logic           m1_ready;
   logic [Y_W-1:0] m1_y;
   logic [X_W-1:0] q_x;
   logic [Y_W-1:0] q_y;
   logic           busy;

   modport slave (
      input  s0_valid, s0_x, s1_valid, s1_x,
      input  m0_ready, m1_ready, q_y,
      output s0_ready, s1_ready,
      output m0_valid, m0_y, m1_valid, m1_y,
      output q_x, busy
   );

   modport master (
      output s0_valid, s0_x, s1_valid, s1_x,
      output m0_ready, m1_ready, q_y,
      input  s0_ready, s1_ready,
      input  m0_valid, m0_y, m1_valid, m1_y,
      input  q_x, busy
   );
endinterface

// File: rtl/quadra_sched.sv
// Round-robin two-requester scheduler for one shared quadra pipeline,
// with latency-matched tag tracking and credit-protected output FIFOs.
module quadra_sched #(
   parameter int LAT        = 3,
   parameter int FIFO_DEPTH = 4
) (
   input logic           clk,
   input logic           rst_b,
   quadra_sched_if.slave bus
);
   localparam int X_W = 8;
   localparam int Y_W = 16;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(FIFO_DEPTH);

   logic [1:0]     s_valid;
   logic [1:0]     m_ready;
   logic [1:0]     elig;
   logic [1:0]     grant;
   logic [1:0]     push;
   logic [1:0]     pop;
   logic [1:0]     nempty;
   logic           last_q, last_d;
   logic           busy_q, busy_d;
   logic [LAT-1:0] vld_q, vld_d;
   logic [LAT-1:0] tag_q, tag_d;
   logic [CW-1:0]  cnt_q [2];
   logic [CW-1:0]  cnt_d [2];
   logic [AW:0]    wp_q [2];
   logic [AW:0]    wp_d [2];
   logic [AW:0]    rp_q [2];
   logic [AW:0]    rp_d [2];
   logic [Y_W-1:0] mem_q [2][FIFO_DEPTH];
   logic [Y_W-1:0] head [2];

   assign s_valid = {bus.s1_valid, bus.s0_valid};
   assign m_ready = {bus.m1_ready, bus.m0_ready};

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         elig[i] = s_valid[i] && (cnt_q[i] < CNT_MAX);
      end
      grant[0] = elig[0] && (!elig[1] || last_q);
      grant[1] = elig[1] && (!elig[0] || !last_q);
   end

   always_comb begin
      bus.q_x = '0;
      last_d  = last_q;
      unique case (1'b1)
         grant[0]: begin
            bus.q_x = bus.s0_x;
            last_d  = 1'b0;
         end
         grant[1]: begin
            bus.q_x = bus.s1_x;
            last_d  = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.s0_ready = grant[0];
   assign bus.s1_ready = grant[1];

   // quadra never stalls, so the tag line shifts every cycle
   always_comb begin
      vld_d = (vld_q << 1) | LAT'(|grant);
      tag_d = (tag_q << 1) | LAT'(grant[1]);
   end

   always_comb begin
      push[0] = vld_q[LAT-1] && !tag_q[LAT-1];
      push[1] = vld_q[LAT-1] &&  tag_q[LAT-1];
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         nempty[i] = wp_q[i] != rp_q[i];
         pop[i]    = nempty[i] && m_ready[i];
         head[i]   = nempty[i] ? mem_q[i][rp_q[i][AW-1:0]] : '0;
         wp_d[i]   = wp_q[i] + (AW+1)'(push[i]);
         rp_d[i]   = rp_q[i] + (AW+1)'(pop[i]);
         cnt_d[i]  = cnt_q[i];
         unique case ({grant[i], pop[i]})
            2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
            2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
            default: cnt_d[i] = cnt_q[i];
         endcase
      end
      busy_d = (cnt_d[0] != '0) || (cnt_d[1] != '0);
   end

   assign bus.m0_valid = nempty[0];
   assign bus.m1_valid = nempty[1];
   assign bus.m0_y     = head[0];
   assign bus.m1_y     = head[1];
   assign bus.busy     = busy_q;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         last_q <= 1'b1;
         busy_q <= 1'b0;
         vld_q  <= '0;
         tag_q  <= '0;
         for (int i = 0; i < 2; i++) begin
            cnt_q[i] <= '0;
            wp_q[i]  <= '0;
            rp_q[i]  <= '0;
         end
      end else begin
         last_q <= last_d;
         busy_q <= busy_d;
         vld_q  <= vld_d;
         tag_q  <= tag_d;
         for (int i = 0; i < 2; i++) begin
            cnt_q[i] <= cnt_d[i];
            wp_q[i]  <= wp_d[i];
            rp_q[i]  <= rp_d[i];
         end
      end
   end

   // storage needs no reset: visibility is governed by the pointers
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (push[i]) begin
            mem_q[i][wp_q[i][AW-1:0]] <= bus.q_y;
         end
      end
   end
endmodule

// File: tb/tb_quadra_sched.sv
// Self-checking bench for quadra_sched: vector table, directed corner
// sequences and random traffic against a queue-based scheduler model.
module tb_quadra_sched;
   localparam int LAT   = 3;
   localparam int DEPTH = 4;

   typedef struct {
      int          t;
      logic [15:0] y;
   } ent_t;

   typedef struct {
      bit          s0v;
      logic [7:0]  s0x;
      bit          m0r;
      bit          e_rdy0;
      bit          e_mv0;
      bit          e_busy;
   } vec_t;

   logic clk = 1'b0;
   logic rst_b = 1'b0;
   always #5 clk = ~clk;

   quadra_sched_if bus ();

   quadra_sched #(
      .LAT       (LAT),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk  (clk),
      .rst_b(rst_b),
      .bus  (bus)
   );

   function automatic logic [15:0] f(input logic [7:0] x);
      logic [15:0] v;
      v = {8'h00, x};
      return v * v + 16'd7 * v + 16'h1234;
   endfunction

   logic [15:0] pipe [LAT];
   always @(posedge clk) begin
      pipe[0] <= f(bus.q_x);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign bus.q_y = pipe[LAT-1];

   ent_t q0[$];
   ent_t q1[$];
   bit   mlast;
   int   cyc;
   int   passed;
   int   total;

   bit          a_rdy0, a_rdy1, a_mv0, a_mv1, a_busy;
   logic [15:0] a_my0, a_my1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                    nm, act, exp, cyc);
   endtask

   task automatic drive(input bit s0v, input logic [7:0] s0x,
                        input bit s1v, input logic [7:0] s1x,
                        input bit m0r, input bit m1r);
      bus.s0_valid = s0v;
      bus.s0_x     = s0x;
      bus.s1_valid = s1v;
      bus.s1_x     = s1x;
      bus.m0_ready = m0r;
      bus.m1_ready = m1r;
   endtask

   // One clock: compare DUT against the model, then advance the model.
   task automatic step();
      int          n0, n1;
      bit          e0, e1, g0, g1, mv0, mv1;
      logic [15:0] y0, y1;
      logic [7:0]  qx;
      ent_t        e;
      @(negedge clk);
      n0  = q0.size();
      n1  = q1.size();
      e0  = bus.s0_valid && (n0 < DEPTH);
      e1  = bus.s1_valid && (n1 < DEPTH);
      g0  = e0 && (!e1 || mlast);
      g1  = e1 && (!e0 || !mlast);
      mv0 = 1'b0;
      mv1 = 1'b0;
      if (n0 > 0) mv0 = q0[0].t <= cyc;
      if (n1 > 0) mv1 = q1[0].t <= cyc;
      y0  = mv0 ? q0[0].y : 16'h0;
      y1  = mv1 ? q1[0].y : 16'h0;
      qx  = g0 ? bus.s0_x : (g1 ? bus.s1_x : 8'h00);
      a_rdy0 = bus.s0_ready;
      a_rdy1 = bus.s1_ready;
      a_mv0  = bus.m0_valid;
      a_mv1  = bus.m1_valid;
      a_my0  = bus.m0_y;
      a_my1  = bus.m1_y;
      a_busy = bus.busy;
      chk("s0_ready", 32'(a_rdy0), 32'(g0));
      chk("s1_ready", 32'(a_rdy1), 32'(g1));
      chk("m0_valid", 32'(a_mv0), 32'(mv0));
      chk("m1_valid", 32'(a_mv1), 32'(mv1));
      chk("m0_y", 32'(a_my0), 32'(y0));
      chk("m1_y", 32'(a_my1), 32'(y1));
      chk("q_x", 32'(bus.q_x), 32'(qx));
      chk("busy", 32'(a_busy), 32'((n0 + n1) != 0));
      if (mv0 && bus.m0_ready) void'(q0.pop_front());
      if (mv1 && bus.m1_ready) void'(q1.pop_front());
      if (g0) begin
         e.t = cyc + LAT + 1;
         e.y = f(bus.s0_x);
         q0.push_back(e);
         mlast = 1'b0;
      end
      if (g1) begin
         e.t = cyc + LAT + 1;
         e.y = f(bus.s1_x);
         q1.push_back(e);
         mlast = 1'b1;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst_b = 1'b0;
      drive(0, 8'h00, 0, 8'h00, 0, 0);
      q0.delete();
      q1.delete();
      mlast = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_b = 1'b1;
      cyc = 0;
   endtask

   vec_t tbl [10];
   int   cnt;
   int   got;
   bit   found;
   logic [15:0] yv;

   initial begin
      passed = 0;
      total  = 0;
      cyc    = 0;
      for (int i = 0; i < 10; i++) tbl[i] = '{0, 8'h00, 0, 0, 0, 0};
      tbl[2] = '{1, 8'h10, 0, 1, 0, 0};
      tbl[3].e_busy = 1;
      tbl[4].e_busy = 1;
      tbl[5].e_busy = 1;
      tbl[6] = '{0, 8'h00, 0, 0, 1, 1};
      tbl[7] = '{0, 8'h00, 1, 0, 1, 1};

      // single sample, explicit cycle table
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].s0v, tbl[i].s0x, 0, 8'h00, tbl[i].m0r, 0);
         step();
         chk($sformatf("tbl%0d rdy0", i), 32'(a_rdy0), 32'(tbl[i].e_rdy0));
         chk($sformatf("tbl%0d mv0", i), 32'(a_mv0), 32'(tbl[i].e_mv0));
         chk($sformatf("tbl%0d busy", i), 32'(a_busy), 32'(tbl[i].e_busy));
         chk($sformatf("tbl%0d m0_y", i), 32'(a_my0),
             tbl[i].e_mv0 ? 32'(f(8'h10)) : 32'h0);
      end

      // contention: strict alternation from s0
      do_reset();
      for (int k = 0; k < 16; k++) begin
         drive(1, 8'($urandom), 1, 8'($urandom), 1, 1);
         step();
         chk("alt s0", 32'(a_rdy0), 32'(k % 2 == 0));
      end
      drive(0, 8'h00, 0, 8'h00, 1, 1);
      repeat (8) step();

      // backpressure up to the credit limit
      do_reset();
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         drive(1, 8'(8'h40 + k), 0, 8'h00, 0, 0);
         step();
         if (a_rdy0) cnt++;
      end
      chk("bp handshakes", 32'(cnt), 32'd4);
      chk("bp stalled", 32'(a_rdy0), 32'd0);
      drive(1, 8'h50, 0, 8'h00, 1, 0);
      step();
      chk("bp pop stall", 32'(a_rdy0), 32'd0);
      // issue and pop together: credit stays at 3
      drive(1, 8'h51, 0, 8'h00, 1, 0);
      step();
      chk("bp refill", 32'(a_rdy0), 32'd1);
      cnt = 0;
      for (int k = 0; k < 5; k++) begin
         drive(1, 8'(8'h52 + k), 0, 8'h00, 0, 0);
         step();
         if (a_rdy0) cnt++;
      end
      chk("issue+pop credit", 32'(cnt), 32'd1);
      drive(0, 8'h00, 0, 8'h00, 1, 0);
      repeat (10) step();
      chk("bp drained", 32'(q0.size()), 32'd0);

      // wrap-around on s1 with random consumer
      do_reset();
      cnt = 0;
      got = 0;
      for (int k = 0; k < 400 && (cnt < 20 || q1.size() != 0); k++) begin
         drive(0, 8'h00, cnt < 20, 8'($urandom),
               0, (cnt >= 20) || ($urandom_range(0, 1) == 1));
         step();
         if (a_rdy1) cnt++;
         if (a_mv1 && bus.m1_ready) got++;
      end
      chk("wrap sent", 32'(cnt), 32'd20);
      chk("wrap received", 32'(got), 32'd20);

      // reset with 3 in flight and 2 buffered
      do_reset();
      drive(1, 8'hA1, 0, 8'h00, 0, 0);
      step();
      drive(1, 8'hA2, 0, 8'h00, 0, 0);
      step();
      for (int k = 0; k < 3; k++) begin
         drive(0, 8'h00, 1, 8'(8'hB0 + k), 0, 0);
         step();
      end
      drive(0, 8'h00, 0, 8'h00, 0, 0);
      chk("pre-rst m0_valid", 32'(bus.m0_valid), 32'd1);
      #2;
      rst_b = 1'b0;
      #1;
      chk("rst m0_valid", 32'(bus.m0_valid), 32'd0);
      chk("rst m1_valid", 32'(bus.m1_valid), 32'd0);
      chk("rst busy", 32'(bus.busy), 32'd0);
      q0.delete();
      q1.delete();
      mlast = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_b = 1'b1;
      cyc = 0;
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         drive(0, 8'h00, 0, 8'h00, 1, 1);
         step();
         if (a_mv0 || a_mv1) cnt++;
      end
      chk("no stale result", 32'(cnt), 32'd0);
      drive(1, 8'h5A, 0, 8'h00, 1, 1);
      step();
      found = 1'b0;
      yv = 16'h0;
      for (int k = 0; k < 10 && !found; k++) begin
         drive(0, 8'h00, 0, 8'h00, 1, 1);
         step();
         if (a_mv0) begin
            found = 1'b1;
            yv = a_my0;
         end
      end
      chk("post-rst found", 32'(found), 32'd1);
      chk("post-rst y", 32'(yv), 32'(f(8'h5A)));

      // random traffic
      do_reset();
      for (int k = 0; k < 400; k++) begin
         drive($urandom_range(0, 3) != 0, 8'($urandom),
               $urandom_range(0, 3) != 0, 8'($urandom),
               $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1);
         step();
      end
      drive(0, 8'h00, 0, 8'h00, 1, 1);
      repeat (12) step();
      chk("random drained", 32'(q0.size() + q1.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
